serial_word_feeder: RTL and testbench

//   Parallel-to-serial front end for shift_register. Accepts a WIDTH-bit word over a valid/ready

---
 rtl/serial_word_feeder_if.sv | 21 ++
 rtl/serial_word_feeder.sv | 124 ++++++++++++
 tb/tb_serial_word_feeder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_feeder_if.sv
// Word handshake between an upstream producer and serial_word_feeder.
// The producer drives valid/data; the feeder answers with ready.
interface serial_word_feeder_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end for a gated-clock shift register.
// One guard LOAD cycle, then one bit strobe every DIV clocks.
module serial_word_feeder #(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  serial_word_feeder_if.slave in_if,
  input  logic                flush,
  output logic                data_out,
  output logic                shift_en,
  output logic                busy,
  output logic                word_done
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(DIV + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             data_out_q, data_out_d;
  logic             shift_en_q, shift_en_d;
  logic             busy_q, busy_d;
  logic             word_done_q, word_done_d;
  logic             accept;
  logic [WIDTH-1:0] sr_nx;

  function automatic logic first_bit(
    input logic [WIDTH-1:0] w
  );
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign in_if.in_ready = (state_q == IDLE) && !rst;
  assign accept = in_if.in_valid && in_if.in_ready && !flush;
  assign sr_nx  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    data_out_d = data_out_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept) begin
          state_d    = LOAD;
          sr_d       = in_if.in_data;
          data_out_d = first_bit(in_if.in_data);
        end
      end
      (state_q == LOAD): begin
        state_d   = SHIFT;
        div_cnt_d = '0;
      end
      (state_q == SHIFT): begin
        if (shift_en_q) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = IDLE;
          end else begin
            sr_d       = sr_nx;
            data_out_d = first_bit(sr_nx);
            bit_cnt_d  = bit_cnt_q + BW'(1);
            div_cnt_d  = '0;
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && flush) begin
      state_d = IDLE;
    end
    // Idle keeps the serial line quiet and counters parked at zero.
    if (state_d == IDLE) begin
      sr_d       = '0;
      data_out_d = 1'b0;
      bit_cnt_d  = '0;
      div_cnt_d  = '0;
    end
    shift_en_d  = (state_d == SHIFT)
               && (div_cnt_d == LAST_DIV);
    word_done_d = shift_en_d
               && (bit_cnt_d == LAST_BIT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      data_out_q  <= 1'b0;
      shift_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      data_out_q  <= data_out_d;
      shift_en_q  <= shift_en_d;
      busy_q      <= busy_d;
      word_done_q <= word_done_d;
    end
  end

  assign data_out  = data_out_q;
  assign shift_en  = shift_en_q;
  assign busy      = busy_q;
  assign word_done = word_done_q;
endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: two instances (DIV=1 LSB-first,
// DIV=3 MSB-first) against a timeline model and a bit scoreboard.
module tb_serial_word_feeder;
  localparam int W  = 4;
  localparam int D0 = 1;
  localparam int D1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   rst   = 2'b11;
  logic [1:0]   vld   = 2'b00;
  logic [1:0]   flush = 2'b00;
  logic [W-1:0] din [2];
  wire  [1:0]   rdy, dout, se, bsy, wd;

  serial_word_feeder_if #(.WIDTH(W)) if0 ();
  serial_word_feeder_if #(.WIDTH(W)) if1 ();

  assign if0.in_valid = vld[0];
  assign if0.in_data  = din[0];
  assign rdy[0]       = if0.in_ready;
  assign if1.in_valid = vld[1];
  assign if1.in_data  = din[1];
  assign rdy[1]       = if1.in_ready;

  serial_word_feeder #(
    .WIDTH(W), .DIV(D0), .MSB_FIRST(1'b0)
  ) u0 (
    .clk(clk), .rst(rst[0]), .in_if(if0),
    .flush(flush[0]), .data_out(dout[0]),
    .shift_en(se[0]), .busy(bsy[0]),
    .word_done(wd[0])
  );

  serial_word_feeder #(
    .WIDTH(W), .DIV(D1), .MSB_FIRST(1'b1)
  ) u1 (
    .clk(clk), .rst(rst[1]), .in_if(if1),
    .flush(flush[1]), .data_out(dout[1]),
    .shift_en(se[1]), .busy(bsy[1]),
    .word_done(wd[1])
  );

  int           ncmp = 0;
  int           nerr = 0;
  int           cyc  = 0;
  bit           en   = 1'b0;
  bit   [1:0]   infl = 2'b00;
  bit   [1:0]   accp = 2'b00;
  int           acc  [2];
  logic [W-1:0] word [2];
  logic [W-1:0] fin  [2];
  logic [W-1:0] sreg [2];
  bit           sbq  [2][$];

  function automatic int dv_of(input int u);
    return (u != 0) ? D1 : D0;
  endfunction

  function automatic logic seqbit(input int u, input int i);
    logic [W-1:0] w;
    w = word[u];
    return (u != 0) ? w[W-1-i] : w[i];
  endfunction

  function automatic void chk(input string nm, input int u,
                              input logic [31:0] a,
                              input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s u%0d: got %0h expected %0h t=%0t",
               nm, u, a, e, $time);
    end
  endfunction

  // Expected bit stream and chained-register result of a word.
  task automatic put(input int u, input logic [W-1:0] w);
    word[u] = w;
    for (int i = 0; i < W; i++) begin
      sbq[u].push_back((u != 0) ? w[W-1-i] : w[i]);
      fin[u][i] = (u != 0) ? w[W-1-i] : w[i];
    end
    accp[u] = 1'b1;
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (rst[u]) begin
        infl[u] = 1'b0;
        sbq[u].delete();
      end else if (infl[u]) begin
        if (cyc - 1 - acc[u] == W * dv_of(u)) begin
          infl[u] = 1'b0;
          chk("leftover_bits", u, sbq[u].size(), 0);
        end else if (flush[u]) begin
          infl[u] = 1'b0;
          sbq[u].delete();
        end
      end else if (accp[u]) begin
        infl[u] = 1'b1;
        acc[u]  = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      for (int u = 0; u < 2; u++) begin
        int   d, dv, idx;
        logic ese, ewd, edo;
        dv  = dv_of(u);
        d   = cyc - acc[u];
        ese = infl[u] && d > 0 && (d % dv) == 0;
        ewd = infl[u] && d == W * dv;
        edo = 1'b0;
        if (infl[u]) begin
          idx = (d == 0) ? 0 : (d - 1) / dv;
          edo = seqbit(u, idx);
        end
        chk("in_ready", u, rdy[u], !rst[u] && !infl[u]);
        chk("busy", u, bsy[u], infl[u]);
        chk("shift_en", u, se[u], ese);
        chk("word_done", u, wd[u], ewd);
        chk("data_out", u, dout[u], edo);
        if (se[u] === 1'b1) begin
          if (sbq[u].size() == 0) begin
            ncmp++;
            nerr++;
            $display("FAIL strobe_extra u%0d: got strobe expected none",
                     u);
          end else begin
            chk("strobe_bit", u, dout[u], sbq[u].pop_front());
          end
          sreg[u] = {dout[u], sreg[u][W-1:1]};
          if (wd[u] === 1'b1) begin
            chk("chained_word", u, sreg[u], fin[u]);
          end
        end
      end
    end
  end

  task automatic send(input int u, input logic [W-1:0] w,
                      input bit hold, input int fl,
                      input int ra, input bit fwin);
    bit ok;
    ok     = 1'b0;
    din[u] = w;
    vld[u] = 1'b1;
    if (fwin) flush[u] = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (!rst[u] && !infl[u] && !flush[u]) begin
        put(u, w);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      flush[u] = 1'b0;
      accp[u]  = 1'b0;
    end
    if (!ok) begin
      ncmp++;
      nerr++;
      $display("FAIL accept_timeout u%0d: got no accept", u);
    end
    din[u] = W'($urandom);
    if (!hold) begin
      vld[u] = 1'b0;
      for (int n = 0; n < 200 && infl[u]; n++) begin
        if (n == fl) flush[u] = 1'b1;
        if (n == ra) begin
          rst[u] = 1'b1;
          vld[u] = 1'b1;
        end
        @(posedge clk);
        #1;
        flush[u] = 1'b0;
        if (n == ra) begin
          @(posedge clk);
          #1;
          rst[u] = 1'b0;
          vld[u] = 1'b0;
        end
      end
      if (infl[u]) begin
        ncmp++;
        nerr++;
        $display("FAIL done_timeout u%0d: word still in flight", u);
      end
    end
  endtask

  task automatic stream(input int u);
    int dv, r, fl, ra;
    bit prev_hold;
    dv = dv_of(u);
    send(u, (u != 0) ? 4'b1000 : 4'b1011, 0, -1, -1, 0);
    send(u, 4'b0110, 0, -1, -1, 0);
    send(u, 4'hA, 1, -1, -1, 0);
    send(u, 4'h5, 0, -1, -1, 0);
    send(u, 4'hF, 0, 2 * dv + 1, -1, 0);
    send(u, W'($urandom), 0, -1, -1, 0);
    repeat (2) @(posedge clk);
    #1;
    send(u, W'($urandom), 0, -1, -1, 1);
    send(u, W'($urandom), 0, -1, 1 + dv, 0);
    prev_hold = 1'b0;
    for (int i = 0; i < 30; i++) begin
      r  = int'($urandom_range(0, 9));
      fl = (r == 1) ? int'($urandom_range(0, W * dv)) : -1;
      ra = (r == 2) ? int'($urandom_range(1, W * dv)) : -1;
      send(u, W'($urandom), r == 0, fl, ra,
           (r == 3) && !prev_hold);
      prev_hold = (r == 0);
    end
    send(u, W'($urandom), 0, -1, -1, 0);
  endtask

  initial begin
    din[0]  = '0;
    din[1]  = '0;
    sreg[0] = '0;
    sreg[1] = '0;
    acc[0]  = 0;
    acc[1]  = 0;
    @(posedge clk);
    #1;
    en = 1'b1;
    @(posedge clk);
    #1;
    rst = 2'b00;
    fork
      stream(0);
      stream(1);
    join
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end
endmodule
